multicycle_shifter: RTL and testbench

Iterative 32-bit shift unit for the processor's ALU path that drives the fixed-distance shift stages (16, 8, 4, 2, 1 bits) one stage per cycle instead of chaining all five combinationally. It accepts one operand plus a 5-bit shift amount over a valid/ready handshake and performs SLL or SRA. It returns the result over a second valid/ready handshake. It sits between the decode/issue logic and the writeback mux, in the slot the combinational barrel shifter occupies in the single-cycle datapath.

---
 rtl/multicycle_shifter.sv | 92 +++++++++
 tb/tb_multicycle_shifter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_shifter.sv
// Iterative 32-bit SLL/SRA unit. It applies one fixed-distance stage per
// cycle (16, 8, 4, 2, 1), so every operation takes 5 shift cycles.
module multicycle_shifter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_operand,
  input  logic [4:0]  shamt,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Request fields captured at accept time and held for the whole operation.
  typedef struct packed {
    logic [4:0] shamt;
    logic       op;    // 0 = SLL, 1 = SRA
    logic       sign;  // operand bit 31 at accept; the SRA fill value
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [2:0]  stage;   // 4..0 selects shift distance 16..1
  logic [31:0] work;
  logic [31:0] staged;  // work after the current stage, if that stage is enabled
  logic        fill;

  assign fill = req.op & req.sign;

  // Apply the stage chosen by the counter when its shamt bit is set.
  always_comb begin
    staged = work;
    case (stage)
      3'd4: if (req.shamt[4]) staged = req.op ? {{16{fill}}, work[31:16]} : {work[15:0], 16'b0};
      3'd3: if (req.shamt[3]) staged = req.op ? {{8{fill}},  work[31:8]}  : {work[23:0], 8'b0};
      3'd2: if (req.shamt[2]) staged = req.op ? {{4{fill}},  work[31:4]}  : {work[27:0], 4'b0};
      3'd1: if (req.shamt[1]) staged = req.op ? {{2{fill}},  work[31:2]}  : {work[29:0], 2'b0};
      3'd0: if (req.shamt[0]) staged = req.op ? {fill,       work[31:1]}  : {work[30:0], 1'b0};
      default: staged = work;
    endcase
  end

  // Next-state logic: accept in IDLE, walk all five stages, hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = SHIFT;
      SHIFT:   if (stage == 3'd0)   state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Operand capture on accept and per-stage update of the working register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work  <= '0;
      req   <= '0;
      stage <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= data_operand;
          req   <= '{shamt: shamt, op: op, sign: data_operand[31]};
          stage <= 3'd4;
        end
        SHIFT: begin
          work <= staged;
          if (stage != 3'd0) stage <= stage - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = work;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Self-checking bench for multicycle_shifter: directed cases plus random
// operations checked against a plain-arithmetic shift model.
module tb_multicycle_shifter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_operand = '0;
  logic [4:0]  shamt = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  multicycle_shifter dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_operand(data_operand), .shamt(shamt), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic o);
    if (o) return 32'($signed(d) >>> s);
    return d << s;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock); #1; cyc++;
  endtask

  // Issue one operation, check latency, result and optional backpressure stability.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic o, input int bp);
    logic [31:0] exp;
    int n;
    exp = model(d, s, o);
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; data_operand = d; shamt = s; op = o;
    out_ready = (bp == 0);
    step();
    in_valid = 1'b0;
    chk("busy_after_accept", {30'b0, busy, in_ready}, 32'b10);
    n = 0;
    while (!out_valid && n < 20) begin
      // Garbage on the request inputs while busy must not be sampled.
      data_operand = $urandom; shamt = 5'($urandom); op = 1'($urandom);
      in_valid = 1'($urandom);
      step(); n++;
    end
    chk("latency", n, 5);
    chk("result", result, exp);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom); data_operand = $urandom; shamt = 5'($urandom);
      step();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", result, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("after_handshake", {29'b0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    int t0, n;
    logic [31:0] e1, e2;

    // Reset state.
    #12;
    chk("reset_state", {29'b0, in_ready, out_valid, busy}, 32'b100);
    chk("reset_result", result, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    step();

    // Directed cases.
    run_op(32'h0000ABCD, 5'd16, 1'b0, 0);
    run_op(32'h80000000, 5'd31, 1'b1, 0);
    run_op(32'h7FFFFFF0, 5'd4,  1'b1, 0);
    run_op(32'h12345678, 5'd0,  1'b0, 0);
    run_op(32'h00000001, 5'd21, 1'b0, 0);
    chk("sll21_value", model(32'h1, 5'd21, 1'b0), 32'h00200000);
    run_op(32'hDEADBEEF, 5'd7,  1'b1, 10);

    // Reset two cycles after accept.
    in_valid = 1'b1; data_operand = 32'hFFFF0000; shamt = 5'd3; op = 1'b0;
    step(); in_valid = 1'b0;
    step(); step();
    reset_n = 1'b0; #1;
    chk("midop_reset_flags", {29'b0, in_ready, out_valid, busy}, 32'b100);
    chk("midop_reset_result", result, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    run_op(32'h00000001, 5'd1, 1'b0, 0);

    // Back-to-back with in_valid held high.
    e1 = model(32'hF0F0F0F0, 5'd9, 1'b1);
    e2 = model(32'h0000FFFF, 5'd12, 1'b0);
    in_valid = 1'b1; data_operand = 32'hF0F0F0F0; shamt = 5'd9; op = 1'b1; out_ready = 1'b1;
    step(); t0 = cyc;
    data_operand = 32'h0000FFFF; shamt = 5'd12; op = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("b2b_first", result, e1);
    step();  // handshake edge
    chk("b2b_ready_after_hs", {31'b0, in_ready}, 32'd1);
    step();  // second accept
    chk("b2b_accept", {31'b0, busy}, 32'd1);
    chk("b2b_interval", cyc - t0, 7);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("b2b_latency", n, 5);
    chk("b2b_second", result, e2);
    step(); out_ready = 1'b0;

    // Random operations.
    for (int i = 0; i < 40; i++)
      run_op($urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
